// File: rtl/dsm_multibit_cifb.sv
// dsm_multibit_cifb: multi-bit CIFB delta-sigma modulator, ORDER integrators, LEVELS-level quantizer; DSM_DITHER_EN adds LFSR dither.
// Latency: one tick per RUN cycle, out_code registered so the DAC feedback lags one tick.
// Backpressure: one-entry pending register, in_ready = !pending_valid; a starved OSR wrap repeats hold and flags underrun.
module dsm_multibit_cifb #(
  parameter int W         = 24,
  parameter int ORDER     = 2,
  parameter int LEVELS    = 3,
  parameter int OSR       = 16,
  parameter int OVF_LIMIT = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [4:0]   out_code,
  output logic         out_valid,
  output logic         ovf_flag,
  output logic         unf_flag,
  input  logic         clr_flags
);

  localparam int M  = (LEVELS - 1) / 2;
  localparam int LM = $clog2(M);
  localparam int SW = W + 2;
  localparam int XW = W + 4;
  localparam int SH = W - 2 - LM;
  localparam int CW = $clog2(OSR);
  localparam int NW = $clog2(OVF_LIMIT + 1);

  localparam logic signed [XW-1:0] SMAX = {3'b000, {(W+1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = -SMAX;
  localparam logic signed [XW-1:0] RND  = XW'(1) <<< (W - 3 - LM);
  localparam logic signed [XW-1:0] QMAX = XW'(M);
  localparam logic signed [XW-1:0] QMIN = -QMAX;
  localparam logic [CW-1:0] OSR_LAST = CW'(OSR - 1);
  localparam logic [NW-1:0] SAT_LIM  = NW'(OVF_LIMIT);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  state_t                 state_q, state_nxt;
  logic signed [W-1:0]    pend_q, hold_q;
  logic                   pend_vld;
  logic [CW-1:0]          osr_cnt;
  logic [NW-1:0]          sat_cnt, sat_cnt_nxt;
  logic signed [SW-1:0]   s_q   [ORDER];
  logic signed [SW-1:0]   s_nxt [ORDER];
  logic signed [XW-1:0]   stage_in [ORDER];
  logic signed [XW-1:0]   v_x, acc, qx, q_sh, dither;
  logic signed [4:0]      code_q, code_nxt;
  logic                   clamp_any, tick, wrap, start, consume, accept;

  assign in_ready  = ~pend_vld;
  assign out_code  = code_q;
  assign tick      = (state_q == RUN) && en;
  assign wrap      = (osr_cnt == OSR_LAST);
  assign start     = (state_q == IDLE) && en && pend_vld;
  assign consume   = start || (tick && wrap && pend_vld);
  assign accept    = in_valid && ~pend_vld;

`ifdef DSM_DITHER_EN
  localparam logic signed [XW-1:0] DAMP = XW'(1) <<< (W - 5 - LM);
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign dither  = lfsr_q[0] ? DAMP : -DAMP;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else if (tick) begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  assign dither = '0;
`endif

  always_comb begin
    acc       = '0;
    clamp_any = 1'b0;
    v_x       = XW'(code_q) <<< SH;
    stage_in[0] = XW'(hold_q);
    for (int k = 1; k < ORDER; k++) begin
      stage_in[k] = XW'(s_q[k-1] >>> 1);
    end
    for (int k = 0; k < ORDER; k++) begin
      acc = XW'(s_q[k]) + stage_in[k] - v_x;
      if (acc > SMAX) begin
        s_nxt[k]  = SW'(SMAX);
        clamp_any = 1'b1;
      end else if (acc < SMIN) begin
        s_nxt[k]  = SW'(SMIN);
        clamp_any = 1'b1;
      end else begin
        s_nxt[k]  = SW'(acc);
      end
    end
    // Quantizer sees the freshly updated last integrator, not the registered one
    qx   = XW'(s_nxt[ORDER-1]) + RND + dither;
    q_sh = qx >>> SH;
    if (q_sh > QMAX) begin
      code_nxt = 5'(QMAX);
    end else if (q_sh < QMIN) begin
      code_nxt = 5'(QMIN);
    end else begin
      code_nxt = 5'(q_sh);
    end
    sat_cnt_nxt = clamp_any ? sat_cnt + NW'(1) : '0;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:  if (en && pend_vld) state_nxt = RUN;
      RUN: begin
        if (!en)                         state_nxt = IDLE;
        else if (sat_cnt_nxt >= SAT_LIM) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q    <= '0;
      pend_vld  <= 1'b0;
      hold_q    <= '0;
      osr_cnt   <= '0;
      sat_cnt   <= '0;
      code_q    <= '0;
      out_valid <= 1'b0;
      ovf_flag  <= 1'b0;
      unf_flag  <= 1'b0;
      for (int k = 0; k < ORDER; k++) s_q[k] <= '0;
    end else begin
      if (accept) begin
        pend_q   <= in_data;
        pend_vld <= 1'b1;
      end else if (consume) begin
        pend_vld <= 1'b0;
      end
      if (consume) hold_q <= pend_q;

      if (start) begin
        osr_cnt <= '0;
      end else if (tick) begin
        osr_cnt <= wrap ? '0 : osr_cnt + CW'(1);
      end

      // Every non-tick cycle (IDLE, CLEAR, en dropped) leaves the loop at rest
      if (tick) begin
        for (int k = 0; k < ORDER; k++) s_q[k] <= s_nxt[k];
        code_q    <= code_nxt;
        out_valid <= 1'b1;
        sat_cnt   <= sat_cnt_nxt;
      end else begin
        for (int k = 0; k < ORDER; k++) s_q[k] <= '0;
        code_q    <= '0;
        out_valid <= 1'b0;
        sat_cnt   <= '0;
      end

      ovf_flag <= (state_q == CLEAR) | (ovf_flag & ~clr_flags);
      unf_flag <= (tick & wrap & ~pend_vld) | (unf_flag & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_dsm_multibit_cifb.sv
// Directed bench for dsm_multibit_cifb: hand-computed first-tick code tables plus underrun, overload-clear and reset sequences.
module tb_dsm_multibit_cifb;

  logic        clock = 1'b0;
  logic        reset, en, in_valid, in_ready, out_valid, ovf_flag, unf_flag, clr_flags;
  logic [23:0] in_data;
  logic [4:0]  out_code;

  logic        b_en, b_in_valid, b_in_ready, b_out_valid, b_ovf, b_unf, b_clr;
  logic [23:0] b_in_data;
  logic [4:0]  b_out_code;

  always #5 clock = ~clock;

  dsm_multibit_cifb #(.W(24), .ORDER(2), .LEVELS(3), .OSR(16), .OVF_LIMIT(8)) dut (
    .clock(clock), .reset(reset), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_code(out_code), .out_valid(out_valid),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag), .clr_flags(clr_flags)
  );

  dsm_multibit_cifb #(.W(24), .ORDER(4), .LEVELS(3), .OSR(16), .OVF_LIMIT(8)) dut4 (
    .clock(clock), .reset(reset), .en(b_en), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_code(b_out_code), .out_valid(b_out_valid),
    .ovf_flag(b_ovf), .unf_flag(b_unf), .clr_flags(b_clr)
  );

  typedef struct {
    int x;
    int c0, c1, c2, c3;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   code_log[1024];
  int   ref_log[64];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; clr_flags = 1'b0;
    b_en = 1'b0; b_in_valid = 1'b0; b_clr = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic run_ticks(input int n, output int sum);
    int got;
    got = 0;
    sum = 0;
    for (int cy = 0; cy < n + 40 && got < n; cy++) begin
      cyc();
      if (out_valid) begin
        code_log[got] = int'($signed(out_code));
        sum += code_log[got];
        got++;
      end
    end
    check("tick_count", got, n);
  endtask

  initial begin
    int sum, n, mm, ticks, clears, prev_ovf;
    int gap[2];

    // First four codes from rest, hand-derived in FS units (FS = 2^22)
    vecs[0] = '{0,        0, 0,  0,  0};
    vecs[1] = '{2097152,  0, 0,  1,  1};
    vecs[2] = '{-2097152, 0, 0, -1,  0};
    vecs[3] = '{4194304,  0, 1,  1,  1};
    vecs[4] = '{-4194304, 0, 0, -1, -1};
    vecs[5] = '{1048576,  0, 0,  0,  1};
    vecs[6] = '{-1048576, 0, 0,  0, -1};
    in_data = '0;
    b_in_data = '0;

    do_reset();
    check("rst_out_code", int'(out_code), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_ovf", int'(ovf_flag), 0);
    check("rst_unf", int'(unf_flag), 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      in_data = 24'(vecs[i].x);
      in_valid = 1'b1;
      en = 1'b1;
      run_ticks(4, sum);
      check($sformatf("vec%0d_t1", i), code_log[0], vecs[i].c0);
      check($sformatf("vec%0d_t2", i), code_log[1], vecs[i].c1);
      check($sformatf("vec%0d_t3", i), code_log[2], vecs[i].c2);
      check($sformatf("vec%0d_t4", i), code_log[3], vecs[i].c3);
    end

    do_reset();
    in_data = '0; in_valid = 1'b1; en = 1'b1;
    run_ticks(64, sum);
    check("zero_in_sum", sum, 0);
    check("zero_in_unf", int'(unf_flag), 0);

    do_reset();
    in_data = 24'd2097152; in_valid = 1'b1; en = 1'b1;
    run_ticks(1024, sum);
    checks++;
    if (sum < 492 || sum > 532) begin
      errors++;
      $display("FAIL half_fs_mean: sum %0d over 1024 ticks, required 492..532", sum);
    end
    check("half_fs_unf", int'(unf_flag), 0);
    for (int i = 0; i < 64; i++) ref_log[i] = code_log[i];

    // Dropping en parks in IDLE with the pending sample kept
    en = 1'b0;
    cyc();
    check("en_off_valid", int'(out_valid), 0);
    check("en_off_code", int'(out_code), 0);
    cyc();
    check("en_off_pend_kept", int'(in_ready), 0);
    en = 1'b1;
    run_ticks(4, sum);
    check("resume_t1", code_log[0], 0);
    check("resume_t2", code_log[1], 0);
    check("resume_t3", code_log[2], 1);
    check("resume_t4", code_log[3], 1);

    // Single sample then starve: underrun at each wrap, hold keeps repeating
    do_reset();
    in_data = 24'd2097152; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; en = 1'b1;
    n = 0;
    for (int cy = 0; cy < 200 && n < 64; cy++) begin
      clr_flags = (n == 31 || n == 40);
      cyc();
      if (out_valid) begin
        code_log[n] = int'($signed(out_code));
        n++;
        if (n == 15) check("unf_before_wrap", int'(unf_flag), 0);
        if (n == 16) check("unf_first_wrap", int'(unf_flag), 1);
        if (n == 32) check("unf_set_beats_clr", int'(unf_flag), 1);
        if (n == 41) check("unf_clr", int'(unf_flag), 0);
        if (n == 48) check("unf_third_wrap", int'(unf_flag), 1);
      end
    end
    clr_flags = 1'b0;
    check("underrun_ticks", n, 64);
    mm = 0;
    for (int i = 0; i < 64; i++) if (code_log[i] != ref_log[i]) mm++;
    check("hold_repeat_mismatches", mm, 0);

    // Reset in the middle of RUN with the pending slot full
    in_valid = 1'b1;
    cyc();
    check("mid_pend_full", int'(in_ready), 0);
    check("mid_unf_set", int'(unf_flag), 1);
    reset = 1'b1;
    cyc();
    check("mid_rst_code", int'(out_code), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_unf", int'(unf_flag), 0);
    check("mid_rst_ovf", int'(ovf_flag), 0);
    reset = 1'b0; in_valid = 1'b0; en = 1'b0;

    // ORDER=4 overload: s1 clamps from tick 5, eighth clamp at tick 12
    do_reset();
    b_in_data = 24'h7FFFFF; b_in_valid = 1'b1; b_en = 1'b1;
    ticks = 0; clears = 0; prev_ovf = 0;
    gap[0] = -1; gap[1] = -1;
    for (int cy = 0; cy < 200 && clears < 2; cy++) begin
      cyc();
      if (b_out_valid) begin
        ticks++;
      end else if (ticks > 0) begin
        gap[clears] = ticks;
        if (clears == 0) check("ovf_before_clear", prev_ovf, 0);
        check($sformatf("clear%0d_ovf", clears), int'(b_ovf), 1);
        check($sformatf("clear%0d_code", clears), int'(b_out_code), 0);
        clears++;
        ticks = 0;
        cyc();
        check("clear_resume_valid", int'(b_out_valid), 1);
        if (b_out_valid) ticks = 1;
      end
      prev_ovf = int'(b_ovf);
    end
    check("clear_count", clears, 2);
    check("ticks_to_first_clear", gap[0], 12);
    check("ticks_to_second_clear", gap[1], 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
